// File: rtl/axi_interconnect_width_convert_awsplit_pkg.sv
// Shared constants and helpers for the downsizing width-convert stages.
package axi_interconnect_width_convert_awsplit_pkg;

   localparam logic [1:0]  BURST_INCR = 2'b01;
   localparam logic [12:0] BYTES_4K   = 13'h1000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_ISSUE = 2'd2
   } awsplit_state_e;

   // Ceiling log2 for elaboration-time sizing (clog2(1) == 0).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_interconnect_width_convert_awsplit.sv
// Write-address splitter: one wide-slave AW burst becomes 1..N narrow INCR sub-bursts,
// each capped at MAX_BEATS and never crossing 4KB, with one B-merger entry per sub-burst.
module axi_interconnect_width_convert_awsplit
   import axi_interconnect_width_convert_awsplit_pkg::*;
#(
   parameter int WIDTH_ID     = 4,
   parameter int WIDTH_AWUSER = 1,
   parameter int WIDTH_ADDR   = 32,
   parameter int S_DW         = 128,
   parameter int M_DW         = 32,
   parameter int MAX_BEATS    = 256,
   parameter int U_DLY        = 1,
   localparam int W_ID        = (WIDTH_ID == 0) ? 1 : WIDTH_ID,
   localparam int W_USER      = (WIDTH_AWUSER == 0) ? 1 : WIDTH_AWUSER
)
(
   input  logic                  clk_sys,
   input  logic                  rst_n,
   input  logic [W_ID-1:0]       s_awid,
   input  logic [WIDTH_ADDR-1:0] s_awaddr,
   input  logic [7:0]            s_awlen,
   input  logic [W_USER-1:0]     s_awuser,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   output logic [W_ID-1:0]       m_awid,
   output logic [WIDTH_ADDR-1:0] m_awaddr,
   output logic [7:0]            m_awlen,
   output logic [2:0]            m_awsize,
   output logic [1:0]            m_awburst,
   output logic [W_USER-1:0]     m_awuser,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   input  logic                  req_full,
   output logic                  req_en,
   output logic                  req_last
);

   localparam int unsigned R      = S_DW / M_DW;
   localparam int unsigned LOG_R  = clog2(R);
   localparam int unsigned SIZE   = clog2(M_DW / 8);
   localparam int unsigned CNT_W  = 9 + LOG_R;
   localparam int unsigned CW     = (CNT_W > 13) ? CNT_W : 13;
   localparam logic [CW-1:0] MAX_CW = CW'(MAX_BEATS);
   localparam logic [2:0] AWSIZE  = 3'(SIZE);

   awsplit_state_e        state_q;
   logic [W_ID-1:0]       id_q;
   logic [WIDTH_ADDR-1:0] addr_q;
   logic [W_USER-1:0]     user_q;
   logic [CNT_W-1:0]      rem_q;
   logic [CW-1:0]         chunk_q;
   logic                  last_q;
   logic                  s_awready_q;
   logic                  m_awvalid_q;
   logic [WIDTH_ADDR-1:0] m_awaddr_q;
   logic [7:0]            m_awlen_q;
   logic                  req_en_q;
   logic                  req_last_q;

   logic [12:0]           room_bytes_d;
   logic [CW-1:0]         room_beats_d;
   logic [CW-1:0]         rem_ext_d;
   logic [CW-1:0]         capped_d;
   logic [CW-1:0]         chunk_d;
   logic                  last_d;
   logic [CNT_W-1:0]      total_d;
   logic                  unused_dly_s;

   // U_DLY is a simulation-only delay; it is unused in synthesized logic.
   assign unused_dly_s = (U_DLY >= 0);

   // Chunk size: min(remaining, MAX_BEATS, beats left before the next 4KB boundary).
   always_comb begin
      room_bytes_d = BYTES_4K - {1'b0, addr_q[11:0]};
      room_beats_d = CW'(room_bytes_d >> SIZE);
      rem_ext_d    = CW'(rem_q);
      capped_d     = (rem_ext_d < MAX_CW) ? rem_ext_d : MAX_CW;
      chunk_d      = (room_beats_d < capped_d) ? room_beats_d : capped_d;
      last_d       = (chunk_d == rem_ext_d);
      total_d      = (CNT_W'(s_awlen) + CNT_W'(1)) << LOG_R;
   end

   // Split FSM; every output is a register so nothing combinational reaches the ports.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         id_q        <= '0;
         addr_q      <= '0;
         user_q      <= '0;
         rem_q       <= '0;
         chunk_q     <= '0;
         last_q      <= 1'b0;
         s_awready_q <= 1'b0;
         m_awvalid_q <= 1'b0;
         m_awaddr_q  <= '0;
         m_awlen_q   <= 8'd0;
         req_en_q    <= 1'b0;
         req_last_q  <= 1'b0;
      end else begin
         req_en_q   <= 1'b0;
         req_last_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s_awvalid && s_awready_q) begin
                  id_q        <= s_awid;
                  addr_q      <= s_awaddr;
                  user_q      <= s_awuser;
                  rem_q       <= total_d;
                  s_awready_q <= 1'b0;
                  state_q     <= ST_CALC;
               end else begin
                  s_awready_q <= 1'b1;
               end
            end
            ST_CALC: begin
               m_awaddr_q <= addr_q;
               m_awlen_q  <= 8'(chunk_d - CW'(1));
               chunk_q    <= chunk_d;
               last_q     <= last_d;
               if (!req_full) begin
                  m_awvalid_q <= 1'b1;
                  state_q     <= ST_ISSUE;
               end else begin
                  state_q     <= ST_CALC;
               end
            end
            ST_ISSUE: begin
               if (m_awready) begin
                  addr_q      <= addr_q + (WIDTH_ADDR'(chunk_q) << SIZE);
                  rem_q       <= rem_q - CNT_W'(chunk_q);
                  m_awvalid_q <= 1'b0;
                  req_en_q    <= 1'b1;
                  req_last_q  <= last_q;
                  if (last_q) begin
                     s_awready_q <= 1'b1;
                     state_q     <= ST_IDLE;
                  end else begin
                     state_q     <= ST_CALC;
                  end
               end else begin
                  state_q <= ST_ISSUE;
               end
            end
            default: begin
               m_awvalid_q <= 1'b0;
               s_awready_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_awready = s_awready_q;
   assign m_awid    = id_q;
   assign m_awaddr  = m_awaddr_q;
   assign m_awlen   = m_awlen_q;
   assign m_awsize  = AWSIZE;
   assign m_awburst = BURST_INCR;
   assign m_awuser  = user_q;
   assign m_awvalid = m_awvalid_q;
   assign req_en    = req_en_q;
   assign req_last  = req_last_q;

endmodule

// File: tb/tb_axi_interconnect_width_convert_awsplit.sv
// Scoreboard bench for the AW splitter: tests queue expected sub-bursts, a negedge monitor checks them.
module tb_axi_interconnect_width_convert_awsplit;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic [3:0]  s_awid;
   logic [31:0] s_awaddr;
   logic [7:0]  s_awlen;
   logic [0:0]  s_awuser;
   logic        s_awvalid;
   logic        s_awready;
   logic [3:0]  m_awid;
   logic [31:0] m_awaddr;
   logic [7:0]  m_awlen;
   logic [2:0]  m_awsize;
   logic [1:0]  m_awburst;
   logic [0:0]  m_awuser;
   logic        m_awvalid;
   logic        m_awready;
   logic        req_full;
   logic        req_en;
   logic        req_last;

   always #5 clk_sys = ~clk_sys;

   axi_interconnect_width_convert_awsplit #(
      .WIDTH_ID(4), .WIDTH_AWUSER(1), .WIDTH_ADDR(32),
      .S_DW(128), .M_DW(32), .MAX_BEATS(256), .U_DLY(1)
   ) dut (
      .clk_sys(clk_sys), .rst_n(rst_n),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awuser(s_awuser),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awuser(m_awuser), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .req_full(req_full), .req_en(req_en), .req_last(req_last)
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [3:0]  id;
      logic [0:0]  user;
   } exp_aw_t;

   exp_aw_t aw_q[$];
   logic    req_q[$];
   int      total = 0;
   int      bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input logic [0:0] user, input logic last);
      exp_aw_t e;
      e.addr = addr;
      e.len  = len;
      e.id   = id;
      e.user = user;
      aw_q.push_back(e);
      req_q.push_back(last);
   endtask

   logic        hs_prev    = 1'b0;
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] prev_addr  = 32'd0;
   logic [7:0]  prev_len   = 8'd0;

   // Monitor: pops the scoreboard on every AW handshake / req_en and checks hold-while-stalled.
   always @(negedge clk_sys) begin
      if (!rst_n) begin
         hs_prev    <= 1'b0;
         prev_valid <= 1'b0;
         prev_ready <= 1'b0;
      end else begin
         if (m_awvalid && m_awready) begin
            if (aw_q.size() == 0) begin
               check("aw_queue_nonempty", 64'(aw_q.size()), 64'd1);
            end else begin
               check("m_awaddr", m_awaddr, aw_q[0].addr);
               check("m_awlen", m_awlen, aw_q[0].len);
               check("m_awid", m_awid, aw_q[0].id);
               check("m_awuser", m_awuser, aw_q[0].user);
               check("m_awsize", m_awsize, 64'd2);
               check("m_awburst", m_awburst, 64'd1);
               aw_q.delete(0);
            end
         end
         if (req_en || hs_prev) begin
            check("req_en_after_hs", req_en, hs_prev);
         end
         if (req_en) begin
            if (req_q.size() == 0) begin
               check("req_queue_nonempty", 64'(req_q.size()), 64'd1);
            end else begin
               check("req_last", req_last, req_q[0]);
               req_q.delete(0);
            end
         end else begin
            check("req_last_idle", req_last, 64'd0);
         end
         if (prev_valid && !prev_ready) begin
            check("hold_valid", m_awvalid, 64'd1);
            check("hold_addr", m_awaddr, prev_addr);
            check("hold_len", m_awlen, prev_len);
         end
         hs_prev    <= m_awvalid && m_awready;
         prev_valid <= m_awvalid;
         prev_ready <= m_awready;
         prev_addr  <= m_awaddr;
         prev_len   <= m_awlen;
      end
   end

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [0:0] user);
      logic ok;
      ok = 1'b0;
      @(posedge clk_sys); #1;
      s_awid    = id;
      s_awaddr  = addr;
      s_awlen   = len;
      s_awuser  = user;
      s_awvalid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk_sys);
         if (s_awready) ok = 1'b1;
      end
      check("s_aw_accepted", ok, 64'd1);
      @(posedge clk_sys); #1;
      s_awvalid = 1'b0;
   endtask

   task automatic wait_valid();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk_sys);
         if (m_awvalid) ok = 1'b1;
      end
      check("m_awvalid_seen", ok, 64'd1);
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk_sys);
         if (aw_q.size() == 0 && req_q.size() == 0 && s_awready && !m_awvalid) ok = 1'b1;
      end
      check("drained", ok, 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      s_awid    = 4'd0;
      s_awaddr  = 32'd0;
      s_awlen   = 8'd0;
      s_awuser  = 1'b0;
      s_awvalid = 1'b0;
      m_awready = 1'b1;
      req_full  = 1'b0;
      repeat (2) @(negedge clk_sys);
      check("rst_s_awready", s_awready, 64'd0);
      check("rst_m_awvalid", m_awvalid, 64'd0);
      check("rst_m_awaddr", m_awaddr, 64'd0);
      check("rst_m_awlen", m_awlen, 64'd0);
      check("rst_req_en", req_en, 64'd0);
      check("rst_m_awsize", m_awsize, 64'd2);
      check("rst_m_awburst", m_awburst, 64'd1);
      @(posedge clk_sys); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("idle_s_awready", s_awready, 64'd1);

      // Basic single sub-burst with latency check: CALC cycle, then m_awvalid.
      push_exp(32'h0000_1000, 8'd15, 4'd3, 1'b1, 1'b1);
      send_aw(4'd3, 32'h0000_1000, 8'd3, 1'b1);
      @(negedge clk_sys);
      check("lat_calc_no_valid", m_awvalid, 64'd0);
      check("busy_s_awready", s_awready, 64'd0);
      @(negedge clk_sys);
      check("lat_valid_n_plus_2", m_awvalid, 64'd1);
      wait_idle();

      // MAX_BEATS split.
      push_exp(32'h0000_2000, 8'd255, 4'd5, 1'b0, 1'b0);
      push_exp(32'h0000_2400, 8'd255, 4'd5, 1'b0, 1'b1);
      send_aw(4'd5, 32'h0000_2000, 8'd127, 1'b0);
      wait_idle();

      // 4KB boundary split.
      push_exp(32'h0000_1F80, 8'd31, 4'd9, 1'b1, 1'b0);
      push_exp(32'h0000_2000, 8'd223, 4'd9, 1'b1, 1'b1);
      send_aw(4'd9, 32'h0000_1F80, 8'd63, 1'b1);
      wait_idle();

      // Address wrap at top of address space, also a 4KB split.
      push_exp(32'hFFFF_FFC0, 8'd15, 4'd1, 1'b0, 1'b0);
      push_exp(32'h0000_0000, 8'd47, 4'd1, 1'b0, 1'b1);
      send_aw(4'd1, 32'hFFFF_FFC0, 8'd15, 1'b0);
      wait_idle();

      // Master backpressure for 5 cycles; monitor checks hold and req_en timing.
      m_awready = 1'b0;
      push_exp(32'h0000_3000, 8'd3, 4'd7, 1'b1, 1'b1);
      send_aw(4'd7, 32'h0000_3000, 8'd0, 1'b1);
      wait_valid();
      repeat (5) @(negedge clk_sys);
      check("bp_no_req_en", req_en, 64'd0);
      @(posedge clk_sys); #1;
      m_awready = 1'b1;
      wait_idle();

      // req_full held through CALC: no issue until it drops.
      req_full = 1'b1;
      push_exp(32'h0000_4000, 8'd7, 4'd2, 1'b0, 1'b1);
      send_aw(4'd2, 32'h0000_4000, 8'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         check("full_no_valid", m_awvalid, 64'd0);
      end
      @(posedge clk_sys); #1;
      req_full = 1'b0;
      @(negedge clk_sys);
      check("full_drop_cycle_calc", m_awvalid, 64'd0);
      @(negedge clk_sys);
      check("full_resume_valid", m_awvalid, 64'd1);
      wait_idle();

      // Reset during ISSUE of chunk 1 of 2.
      m_awready = 1'b0;
      send_aw(4'd4, 32'h0000_5000, 8'd127, 1'b1);
      wait_valid();
      @(posedge clk_sys); #3;
      rst_n = 1'b0;
      #1;
      check("arst_m_awvalid", m_awvalid, 64'd0);
      check("arst_req_en", req_en, 64'd0);
      check("arst_s_awready", s_awready, 64'd0);
      check("arst_m_awaddr", m_awaddr, 64'd0);
      @(posedge clk_sys); #1;
      rst_n = 1'b1;
      m_awready = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("post_rst_s_awready", s_awready, 64'd1);
      check("post_rst_m_awvalid", m_awvalid, 64'd0);

      push_exp(32'h0000_6000, 8'd31, 4'd6, 1'b1, 1'b1);
      send_aw(4'd6, 32'h0000_6000, 8'd7, 1'b1);
      wait_idle();

      repeat (3) @(negedge clk_sys);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
